// File: rtl/byte_reg_file_if.sv
// ---------------------------------------------------------------------------
// byte_reg_file_if
//   Bus bundle for byte_reg_file: one byte-enabled write port and two
//   registered read ports.
//   Parameters : WIDTH (entry width, multiple of 8), DEPTH (entry count).
//   Signals    : wr_en/wr_addr/wr_be/wr_data           write port
//                rdN_en/rdN_addr -> rdN_data/rdN_vld   read ports 0 and 1
//   Modports   : master drives requests, slave (the register file) drives
//                read data and valid.
// ---------------------------------------------------------------------------
interface byte_reg_file_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [NB-1:0]    wr_be;
   logic [WIDTH-1:0] wr_data;

   logic             rd0_en;
   logic [AW-1:0]    rd0_addr;
   logic [WIDTH-1:0] rd0_data;
   logic             rd0_vld;

   logic             rd1_en;
   logic [AW-1:0]    rd1_addr;
   logic [WIDTH-1:0] rd1_data;
   logic             rd1_vld;

   modport master (
      output wr_en, wr_addr, wr_be, wr_data,
      output rd0_en, rd0_addr, rd1_en, rd1_addr,
      input  rd0_data, rd0_vld, rd1_data, rd1_vld
   );

   modport slave (
      input  wr_en, wr_addr, wr_be, wr_data,
      input  rd0_en, rd0_addr, rd1_en, rd1_addr,
      output rd0_data, rd0_vld, rd1_data, rd1_vld
   );
endinterface

// File: rtl/byte_reg_file.sv
// ---------------------------------------------------------------------------
// byte_reg_file
//   Bank of DEPTH registers of WIDTH bits with per-byte write enables, one
//   synchronous write port and two independent registered read ports. Each
//   entry carries a valid bit that is set by its first non-empty write and
//   cleared only by reset.
//
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  synchronous reset, active-high; clears entries, valid bits and
//              read outputs, overriding any write/read in that cycle
//     bus  byte_reg_file_if.slave (write port, read ports 0/1, latency 1)
//
//   Build option:
//     BYTE_REG_FILE_BYPASS_EN defined   -> write-through: a read of the entry
//                                          being written captures the merged
//                                          word and vld=1.
//     BYTE_REG_FILE_BYPASS_EN undefined -> read-first: the read captures the
//                                          pre-write contents and valid bit.
//
//   Addresses >= DEPTH (only possible for non power-of-2 DEPTH) ignore
//   writes and read back data=0, vld=0.
// ---------------------------------------------------------------------------
module byte_reg_file #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   byte_reg_file_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   generate
      if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
         $error("byte_reg_file: WIDTH must be a non-zero multiple of 8");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("byte_reg_file: DEPTH must be >= 2");
      end
   endgenerate

   function automatic logic in_range(input logic [AW-1:0] a);
      return (32'(a) < 32'(DEPTH));
   endfunction

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic             w_wr_hit;
   logic [WIDTH-1:0] w_wr_old;
   logic [WIDTH-1:0] w_wr_merged;

   logic             w_rd_en   [2];
   logic [AW-1:0]    w_rd_addr [2];
   logic [WIDTH-1:0] w_rd_data [2];
   logic             w_rd_vld  [2];

   logic [WIDTH-1:0] r_rd_data_p1 [2];
   logic             r_rd_vld_p1  [2];

   assign w_rd_en[0]   = bus.rd0_en;
   assign w_rd_en[1]   = bus.rd1_en;
   assign w_rd_addr[0] = bus.rd0_addr;
   assign w_rd_addr[1] = bus.rd1_addr;

   // A write only counts when it targets a real entry and enables some lane;
   // an all-zero byte enable must not set the valid bit.
   assign w_wr_hit = bus.wr_en && in_range(bus.wr_addr) && (bus.wr_be != '0);

   // Old word with the enabled lanes replaced: the new entry value, and the
   // write-through read value.
   always_comb begin
      w_wr_old = '0;
      if (in_range(bus.wr_addr)) begin
         w_wr_old = r_mem[bus.wr_addr];
      end
      w_wr_merged = w_wr_old;
      for (int i = 0; i < NB; i++) begin
         if (bus.wr_be[i]) begin
            w_wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
         end
      end
   end

   // Read lookup (stage p0): value each port captures at the next edge.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_data[p] = '0;
         w_rd_vld[p]  = 1'b0;
         if (in_range(w_rd_addr[p])) begin
            w_rd_data[p] = r_mem[w_rd_addr[p]];
            w_rd_vld[p]  = r_valid[w_rd_addr[p]];
`ifdef BYTE_REG_FILE_BYPASS_EN
            if (w_wr_hit && (w_rd_addr[p] == bus.wr_addr)) begin
               w_rd_data[p] = w_wr_merged;
               w_rd_vld[p]  = 1'b1;
            end
`endif
         end
      end
   end

   // Storage update
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid <= '0;
      end else if (w_wr_hit) begin
         r_mem[bus.wr_addr]   <= w_wr_merged;
         r_valid[bus.wr_addr] <= 1'b1;
      end
   end

   // Read output registers (stage p1): hold when the port strobe is low.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (rst) begin
            r_rd_data_p1[p] <= '0;
            r_rd_vld_p1[p]  <= 1'b0;
         end else if (w_rd_en[p]) begin
            r_rd_data_p1[p] <= w_rd_data[p];
            r_rd_vld_p1[p]  <= w_rd_vld[p];
         end
      end
   end

   assign bus.rd0_data = r_rd_data_p1[0];
   assign bus.rd0_vld  = r_rd_vld_p1[0];
   assign bus.rd1_data = r_rd_data_p1[1];
   assign bus.rd1_vld  = r_rd_vld_p1[1];
endmodule

// File: tb/tb_byte_reg_file.sv
// ---------------------------------------------------------------------------
// tb_byte_reg_file
//   Bench for byte_reg_file with WIDTH=32, DEPTH=6 (non power of 2, so
//   addresses 6 and 7 are out of range). A behavioural model (array of words
//   plus valid flags) predicts both read ports; a compare process checks the
//   outputs every cycle after the first reset. Directed scenarios add literal
//   expectations, followed by a randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_byte_reg_file;
   localparam int WIDTH = 32;
   localparam int DEPTH = 6;

   logic clk;
   logic rst;

   byte_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   byte_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model
   logic [31:0] mdl_mem [DEPTH];
   bit          mdl_vld [DEPTH];
   logic [31:0] exp_d   [2];
   bit          exp_v   [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic mdl_write();
      int a;
      a = int'(bus.wr_addr);
      for (int i = 0; i < 4; i++) begin
         if (bus.wr_be[i]) mdl_mem[a][8*i +: 8] = bus.wr_data[8*i +: 8];
      end
      mdl_vld[a] = 1'b1;
   endtask

   task automatic mdl_read(input logic [2:0] a, output logic [31:0] d, output bit v);
      if (int'(a) < DEPTH) begin
         d = mdl_mem[int'(a)];
         v = mdl_vld[int'(a)];
      end else begin
         d = '0;
         v = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      bit do_wr;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = '0;
            mdl_vld[i] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            exp_d[p] = '0;
            exp_v[p] = 1'b0;
         end
      end else begin
         do_wr = bus.wr_en && (int'(bus.wr_addr) < DEPTH) && (bus.wr_be != 4'h0);
`ifdef BYTE_REG_FILE_BYPASS_EN
         if (do_wr) mdl_write();
`endif
         if (bus.rd0_en) mdl_read(bus.rd0_addr, exp_d[0], exp_v[0]);
         if (bus.rd1_en) mdl_read(bus.rd1_addr, exp_d[1], exp_v[1]);
`ifndef BYTE_REG_FILE_BYPASS_EN
         if (do_wr) mdl_write();
`endif
      end
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd0_data", bus.rd0_data, exp_d[0]);
         chk("rd0_vld",  32'(bus.rd0_vld), 32'(exp_v[0]));
         chk("rd1_data", bus.rd1_data, exp_d[1]);
         chk("rd1_vld",  32'(bus.rd1_vld), 32'(exp_v[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      rst         = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_be   = '0;
      bus.wr_data = '0;
      bus.rd0_en  = 1'b0;
      bus.rd0_addr = '0;
      bus.rd1_en  = 1'b0;
      bus.rd1_addr = '0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_be   = be;
      bus.wr_data = d;
   endtask

   task automatic rd(input int port, input logic [2:0] a);
      if (port == 0) begin
         bus.rd0_en   = 1'b1;
         bus.rd0_addr = a;
      end else begin
         bus.rd1_en   = 1'b1;
         bus.rd1_addr = a;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] coll_d;
      logic [31:0] coll_v;

      // Reset
      idle();
      rst = 1'b1;
      tick();
      tick();
      chk("reset rd0_data", bus.rd0_data, 32'h0);
      chk("reset rd0_vld",  32'(bus.rd0_vld), 32'h0);
      chk("reset rd1_data", bus.rd1_data, 32'h0);
      chk("reset rd1_vld",  32'(bus.rd1_vld), 32'h0);
      chk_en = 1'b1;
      idle();

      // Every address on both ports reads zero / invalid after reset
      for (int a = 0; a < 8; a++) begin
         idle();
         rd(0, 3'(a));
         rd(1, 3'(7 - a));
         tick();
         chk("post-reset rd0", {bus.rd0_vld, bus.rd0_data[30:0]}, 32'h0);
         chk("post-reset rd1", {bus.rd1_vld, bus.rd1_data[30:0]}, 32'h0);
      end

      // Full write then read
      idle(); wr(3'd3, 4'hF, 32'hDEADBEEF); tick();
      idle(); rd(0, 3'd3); tick();
      chk("full write data", bus.rd0_data, 32'hDEADBEEF);
      chk("full write vld",  32'(bus.rd0_vld), 32'h1);

      // Partial byte write merges with old contents
      idle(); wr(3'd3, 4'b0101, 32'h11223344); tick();
      idle(); rd(0, 3'd3); tick();
      chk("byte merge data", bus.rd0_data, 32'hDE22BE44);
      chk("byte merge vld",  32'(bus.rd0_vld), 32'h1);

      // Zero byte enable is a no-op
      idle(); wr(3'd5, 4'h0, 32'hFFFFFFFF); tick();
      idle(); rd(1, 3'd5); tick();
      chk("be0 data", bus.rd1_data, 32'h0);
      chk("be0 vld",  32'(bus.rd1_vld), 32'h0);

      // Same-cycle write and dual read of addr 2
      idle(); wr(3'd2, 4'hF, 32'hA5A5A5A5); rd(0, 3'd2); rd(1, 3'd2); tick();
`ifdef BYTE_REG_FILE_BYPASS_EN
      coll_d = 32'hA5A5A5A5;
      coll_v = 32'h1;
`else
      coll_d = 32'h0;
      coll_v = 32'h0;
`endif
      chk("collision rd0 data", bus.rd0_data, coll_d);
      chk("collision rd0 vld",  32'(bus.rd0_vld), coll_v);
      chk("collision rd1 data", bus.rd1_data, coll_d);
      chk("collision rd1 vld",  32'(bus.rd1_vld), coll_v);
      idle(); rd(0, 3'd2); rd(1, 3'd2); tick();
      chk("after collision rd0", bus.rd0_data, 32'hA5A5A5A5);
      chk("after collision rd1", bus.rd1_data, 32'hA5A5A5A5);

      // Out of range write/read
      idle(); wr(3'd7, 4'hF, 32'h0BADF00D); tick();
      idle(); rd(0, 3'd7); rd(1, 3'd6); tick();
      chk("oor rd0 data", bus.rd0_data, 32'h0);
      chk("oor rd0 vld",  32'(bus.rd0_vld), 32'h0);
      for (int a = 0; a < DEPTH; a++) begin
         idle(); rd(0, 3'(a)); rd(1, 3'(DEPTH - 1 - a)); tick();
      end

      // Hold: rd0 disabled keeps its last capture while other traffic runs
      idle(); rd(0, 3'd3); tick();
      for (int c = 0; c < 5; c++) begin
         idle();
         wr(3'($urandom_range(0, 7)), 4'($urandom), $urandom);
         rd(1, 3'($urandom_range(0, 7)));
         tick();
         chk("rd0 hold", bus.rd0_data, 32'hDE22BE44);
      end

      // Randomized traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         idle();
         rst = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) != 0)
            wr(3'($urandom_range(0, 7)), 4'($urandom), $urandom);
         if ($urandom_range(0, 2) != 0) rd(0, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 2) != 0) rd(1, 3'($urandom_range(0, 7)));
         tick();
      end

      // Reset in the same cycle as a write and read of addr 1
      idle(); wr(3'd1, 4'hF, 32'h12345678); tick();
      idle(); rst = 1'b1; wr(3'd1, 4'hF, 32'hCAFEF00D); rd(0, 3'd1); rd(1, 3'd1); tick();
      chk("rst collide rd0 data", bus.rd0_data, 32'h0);
      chk("rst collide rd1 data", bus.rd1_data, 32'h0);
      idle(); rd(0, 3'd1); tick();
      chk("post rst read data", bus.rd0_data, 32'h0);
      chk("post rst read vld",  32'(bus.rd0_vld), 32'h0);

      idle();
      tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
